// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        MDU_WAIT  = 2'd2
    } hz_state_e;

    // Default register-address width (32 architectural registers)
    localparam int REG_AW_DEF   = 5;

    // Legal range of load-use bubbles; the bubble counter is sized for the max
    localparam int LOAD_LAT_MIN = 1;
    localparam int LOAD_LAT_MAX = 15;
    localparam int LAT_CW       = 4;

    // Force an out-of-range LOAD_LAT into the legal window so the counter never wraps
    function automatic int clamp_lat(input int lat);
        if (lat < LOAD_LAT_MIN) return LOAD_LAT_MIN;
        if (lat > LOAD_LAT_MAX) return LOAD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// One source-operand vs destination comparator; x0 never produces a hit.
module hazard_src_match #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic              i_rs_used,
    input  logic [REG_AW-1:0] i_rd,
    output logic              o_hit
);

    assign o_hit = i_rs_used && (i_rs == i_rd) && (i_rd != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, MDU busy stalls, branch
// flushes and a saturating stall-cycle counter. Outputs are combinational
// from the inputs and the registered FSM state, so hazards act with zero latency.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_id_ex_memread,
    input  logic [REG_AW-1:0] i_rd_id_ex,
    input  logic [REG_AW-1:0] i_rs1_if_id,
    input  logic [REG_AW-1:0] i_rs2_if_id,
    input  logic              i_rs1_used,
    input  logic              i_rs2_used,
    input  logic              i_id_is_mdu,
    input  logic              i_mdu_busy,
    input  logic [REG_AW-1:0] i_mdu_rd,
    input  logic              i_branch_taken,
    output logic              o_pc_we,
    output logic              o_if_id_we,
    output logic              o_if_id_flush,
    output logic              o_id_ex_flush,
    output logic              o_stall,
    output logic [CNT_W-1:0]  o_stall_cycles
);

    localparam int LAT = clamp_lat(LOAD_LAT);

    hz_state_e         r_state, w_state_nxt;
    logic [LAT_CW-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic w_rs1_ld, w_rs2_ld, w_rs1_mdu, w_rs2_mdu;
    logic w_load_hit, w_mdu_hit, w_stall;

    // Source comparators: both ID operands against the EX load and the MDU destination
    hazard_src_match #(.REG_AW(REG_AW)) u_rs1_ld (
        .i_rs(i_rs1_if_id), .i_rs_used(i_rs1_used), .i_rd(i_rd_id_ex), .o_hit(w_rs1_ld));
    hazard_src_match #(.REG_AW(REG_AW)) u_rs2_ld (
        .i_rs(i_rs2_if_id), .i_rs_used(i_rs2_used), .i_rd(i_rd_id_ex), .o_hit(w_rs2_ld));
    hazard_src_match #(.REG_AW(REG_AW)) u_rs1_mdu (
        .i_rs(i_rs1_if_id), .i_rs_used(i_rs1_used), .i_rd(i_mdu_rd), .o_hit(w_rs1_mdu));
    hazard_src_match #(.REG_AW(REG_AW)) u_rs2_mdu (
        .i_rs(i_rs2_if_id), .i_rs_used(i_rs2_used), .i_rd(i_mdu_rd), .o_hit(w_rs2_mdu));

    // Hazards are masked while reset is held so the front end is released at once
    assign w_load_hit = i_rst_n && i_id_ex_memread && (w_rs1_ld || w_rs2_ld);
    assign w_mdu_hit  = i_rst_n && i_mdu_busy && (i_id_is_mdu || w_rs1_mdu || w_rs2_mdu);

    // State register and load-bubble counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: branch aborts everything, then wait continuation, then load, then MDU
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (i_branch_taken) begin
                    w_state_nxt = IDLE;
                end else if (w_load_hit) begin
                    // The first bubble is taken in IDLE; only the rest need counting
                    if (LAT > 1) begin
                        w_state_nxt = LOAD_WAIT;
                        w_cnt_nxt   = LAT_CW'(LAT - 1);
                    end
                end else if (w_mdu_hit) begin
                    w_state_nxt = MDU_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (i_branch_taken) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt <= LAT_CW'(1)) w_state_nxt = IDLE;
                end
            end
            MDU_WAIT: begin
                if (i_branch_taken || !w_mdu_hit) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: a taken branch squashes the dependent instruction, so it overrides any stall
    always_comb begin
        w_stall = 1'b0;
        unique case (r_state)
            IDLE:      w_stall = w_load_hit || w_mdu_hit;
            LOAD_WAIT: w_stall = (r_cnt != '0);
            MDU_WAIT:  w_stall = w_mdu_hit;
            default:   w_stall = 1'b0;
        endcase
        if (i_branch_taken) w_stall = 1'b0;

        o_stall       = w_stall;
        o_pc_we       = !w_stall;
        o_if_id_we    = !w_stall;
        o_if_id_flush = i_branch_taken;
        o_id_ex_flush = w_stall || i_branch_taken;
    end

    // Saturating performance counter of stalled cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances share one stimulus stream
// (LOAD_LAT=1, LOAD_LAT=3, and a 4-bit counter variant).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       memread, rs1_used, rs2_used, id_is_mdu, mdu_busy, branch;
    logic [4:0] rd_ex, rs1, rs2, mdu_rd;

    logic       pc_we1, ifwe1, iff1, exf1, st1;
    logic       pc_we3, ifwe3, iff3, exf3, st3;
    logic       pc_we4, ifwe4, iff4, exf4, st4;
    logic [31:0] cnt1, cnt3;
    logic [3:0]  cnt4;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_ex_memread(memread), .i_rd_id_ex(rd_ex),
        .i_rs1_if_id(rs1), .i_rs2_if_id(rs2), .i_rs1_used(rs1_used), .i_rs2_used(rs2_used),
        .i_id_is_mdu(id_is_mdu), .i_mdu_busy(mdu_busy), .i_mdu_rd(mdu_rd),
        .i_branch_taken(branch), .o_pc_we(pc_we1), .o_if_id_we(ifwe1),
        .o_if_id_flush(iff1), .o_id_ex_flush(exf1), .o_stall(st1), .o_stall_cycles(cnt1));

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(32)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_ex_memread(memread), .i_rd_id_ex(rd_ex),
        .i_rs1_if_id(rs1), .i_rs2_if_id(rs2), .i_rs1_used(rs1_used), .i_rs2_used(rs2_used),
        .i_id_is_mdu(id_is_mdu), .i_mdu_busy(mdu_busy), .i_mdu_rd(mdu_rd),
        .i_branch_taken(branch), .o_pc_we(pc_we3), .o_if_id_we(ifwe3),
        .o_if_id_flush(iff3), .o_id_ex_flush(exf3), .o_stall(st3), .o_stall_cycles(cnt3));

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_ex_memread(memread), .i_rd_id_ex(rd_ex),
        .i_rs1_if_id(rs1), .i_rs2_if_id(rs2), .i_rs1_used(rs1_used), .i_rs2_used(rs2_used),
        .i_id_is_mdu(id_is_mdu), .i_mdu_busy(mdu_busy), .i_mdu_rd(mdu_rd),
        .i_branch_taken(branch), .o_pc_we(pc_we4), .o_if_id_we(ifwe4),
        .o_if_id_flush(iff4), .o_id_ex_flush(exf4), .o_stall(st4), .o_stall_cycles(cnt4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and checks happen 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        memread = 0; rs1_used = 0; rs2_used = 0; id_is_mdu = 0; mdu_busy = 0; branch = 0;
        rd_ex = 0; rs1 = 0; rs2 = 0; mdu_rd = 0;
    endtask

    // Pulse reset between edges to clear counters and state
    task automatic pulse_reset();
        idle_inputs();
        rst_n = 0;
        #2;
        rst_n = 1;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        #3;
        // Reset state
        chk("rst_pc_we", 32'(pc_we1), 1);
        chk("rst_if_id_we", 32'(ifwe1), 1);
        chk("rst_if_id_flush", 32'(iff1), 0);
        chk("rst_id_ex_flush", 32'(exf1), 0);
        chk("rst_stall", 32'(st1), 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_cnt4", 32'(cnt4), 0);
        tick();
        rst_n = 1;
        tick();

        // Load into x5, rs2 depends on it
        memread = 1; rd_ex = 5; rs2 = 5; rs2_used = 1;
        #1;
        chk("ld_c1_stall_l1", 32'(st1), 1);
        chk("ld_c1_pc_we_l1", 32'(pc_we1), 0);
        chk("ld_c1_exflush_l1", 32'(exf1), 1);
        chk("ld_c1_ifflush_l1", 32'(iff1), 0);
        chk("ld_c1_stall_l3", 32'(st3), 1);
        tick();
        memread = 0;   // bubble now in EX
        #1;
        chk("ld_c2_stall_l1", 32'(st1), 0);
        chk("ld_c2_pc_we_l1", 32'(pc_we1), 1);
        chk("ld_c2_stall_l3", 32'(st3), 1);
        chk("ld_c2_pc_we_l3", 32'(pc_we3), 0);
        tick();
        chk("ld_c3_stall_l3", 32'(st3), 1);
        tick();
        chk("ld_c4_stall_l3", 32'(st3), 0);
        chk("ld_c4_pc_we_l3", 32'(pc_we3), 1);
        chk("ld_cnt_l1", cnt1, 1);
        chk("ld_cnt_l3", cnt3, 3);
        pulse_reset();

        // x0 never hazards; unused operand never hazards
        memread = 1; rd_ex = 0; rs1 = 0; rs1_used = 1;
        #1;
        chk("x0_stall", 32'(st1), 0);
        tick();
        rd_ex = 7; rs1 = 7; rs1_used = 0;
        #1;
        chk("unused_stall", 32'(st3), 0);
        tick();
        idle_inputs();
        #1;
        chk("nohaz_cnt", cnt1, 0);

        // MDU busy for 6 cycles on rs1=x9
        mdu_busy = 1; mdu_rd = 9; rs1 = 9; rs1_used = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("mdu_c%0d_stall", i + 1), 32'(st1), 1);
            tick();
        end
        mdu_busy = 0;
        #1;
        chk("mdu_c7_stall", 32'(st1), 0);
        chk("mdu_c7_pc_we", 32'(pc_we1), 1);
        chk("mdu_cnt", cnt1, 6);
        tick();
        // MDU op in ID waits for busy MDU regardless of registers
        rs1_used = 0; mdu_busy = 1; id_is_mdu = 1;
        #1;
        chk("mdu_op_stall", 32'(st3), 1);
        tick();
        mdu_busy = 0;
        #1;
        chk("mdu_op_release", 32'(st3), 0);
        chk("mdu_op_cnt", cnt3, 7);
        pulse_reset();

        // Branch taken during LOAD_WAIT stall cycle 2
        memread = 1; rd_ex = 5; rs2 = 5; rs2_used = 1;
        tick();
        memread = 0; branch = 1;
        #1;
        chk("br_lw_stall", 32'(st3), 0);
        chk("br_lw_pc_we", 32'(pc_we3), 1);
        chk("br_lw_if_id_we", 32'(ifwe3), 1);
        chk("br_lw_ifflush", 32'(iff3), 1);
        chk("br_lw_exflush", 32'(exf3), 1);
        tick();
        branch = 0;
        #1;
        chk("br_lw_idle_stall", 32'(st3), 0);
        chk("br_lw_cnt", cnt3, 1);
        // Branch overrides a fresh load hit in IDLE
        memread = 1; branch = 1;
        #1;
        chk("br_ld_stall", 32'(st1), 0);
        chk("br_ld_ifflush", 32'(iff1), 1);
        tick();
        pulse_reset();

        // 20 MDU stall cycles: 4-bit counter saturates at 15
        mdu_busy = 1; mdu_rd = 9; rs1 = 9; rs1_used = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt4", 32'(cnt4), 15);
        chk("sat_cnt32", cnt1, 20);
        chk("sat_still_stall", 32'(st1), 1);
        // Asynchronous reset mid MDU_WAIT
        rst_n = 0;
        #1;
        chk("arst_stall", 32'(st1), 0);
        chk("arst_pc_we", 32'(pc_we1), 1);
        chk("arst_exflush", 32'(exf1), 0);
        chk("arst_cnt1", cnt1, 0);
        chk("arst_cnt4", 32'(cnt4), 0);
        mdu_busy = 0;
        tick();
        rst_n = 1;
        #1;
        chk("post_rst_stall", 32'(st1), 0);
        tick();
        chk("post_rst_stall2", 32'(st4), 0);
        chk("post_rst_cnt", cnt1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
